// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the bus-processor instruction sequencer:
// opcodes, register indices, word widths, FSM state and FIFO entry layout.
package proc_sequencer_pkg;

    localparam int INSTR_W = 6;
    localparam int DATA_W  = 8;
    localparam int WORD_W  = INSTR_W + DATA_W;

    localparam logic [1:0] OP_MVI = 2'b00;
    localparam logic [1:0] OP_MV  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // Field order matches the {in_instr, in_data} push word.
    typedef struct packed {
        logic [1:0]        f;
        logic [1:0]        rx;
        logic [1:0]        ry;
        logic [DATA_W-1:0] data;
    } instr_t;

endpackage

// File: rtl/proc_sequencer_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; pushes while full
// and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array carries no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Instruction feeder for the 8-bit bus processor: buffers pushed words,
// issues one at a time with a w strobe, captures BusWires on Done, and
// abandons an instruction that never completes.
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               run,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_data,
    output logic               w,
    output logic [1:0]         F,
    output logic [1:0]         Rx,
    output logic [1:0]         Ry,
    output logic [DATA_W-1:0]  Data,
    input  logic               Done,
    input  logic [DATA_W-1:0]  BusWires,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               busy,
    output logic               error,
    output logic [7:0]         issued_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t                  state;
    logic [WD_W-1:0]         wd_cnt;
    logic [WORD_W-1:0]       fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count_unused;
    logic                    issue;
    instr_t                  head;

    // in_ready comes from the registered count, so a same-cycle pop
    // never opens a slot while full.
    assign in_ready = !fifo_full;
    assign issue    = (state == S_IDLE) && run && !fifo_empty;
    assign head     = instr_t'(fifo_rdata);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (Clock),
        .reset     (Reset),
        .push      (in_valid),
        .push_data ({in_instr, in_data}),
        .pop       (issue),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_IDLE;
            wd_cnt       <= '0;
            w            <= 1'b0;
            F            <= '0;
            Rx           <= '0;
            Ry           <= '0;
            Data         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            issued_cnt   <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        F     <= head.f;
                        Rx    <= head.rx;
                        Ry    <= head.ry;
                        Data  <= head.data;
                        w     <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w      <= 1'b0;
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Fields stay untouched here: the processor reads Data at T1.
                    if (Done) begin
                        result       <= BusWires;
                        result_valid <= 1'b1;
                        issued_cnt   <= issued_cnt + 8'd1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a behavioural bus-processor model
// and a result scoreboard filled at push time.
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       run;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_instr;
    logic [7:0] in_data;
    logic       w;
    logic [1:0] F, Rx, Ry;
    logic [7:0] Data;
    logic       Done;
    logic [7:0] BusWires;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       error;
    logic [7:0] issued_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    proc_sequencer #(.DEPTH(8), .TIMEOUT(15)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .run          (run),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_data      (in_data),
        .w            (w),
        .F            (F),
        .Rx           (Rx),
        .Ry           (Ry),
        .Data         (Data),
        .Done         (Done),
        .BusWires     (BusWires),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .issued_cnt   (issued_cnt)
    );

    always #5 Clock = ~Clock;

    // ---------------- processor model ----------------
    logic [7:0] proc_r [4];
    logic [1:0] proc_step;
    logic [5:0] ir;
    logic [7:0] reg_a, reg_g;
    logic       done_int;
    logic [7:0] bus;
    bit         hang = 1'b0;

    always_comb begin
        done_int = 1'b0;
        bus      = 8'h00;
        if (proc_step == 2'd1 && ir[5:4] == OP_MVI) begin
            done_int = 1'b1;
            bus      = Data;
        end else if (proc_step == 2'd1 && ir[5:4] == OP_MV) begin
            done_int = 1'b1;
            bus      = proc_r[ir[1:0]];
        end else if (proc_step == 2'd3) begin
            done_int = 1'b1;
            bus      = reg_g;
        end
    end

    assign Done     = done_int && !hang;
    assign BusWires = bus;

    always @(posedge Clock) begin
        if (Reset) begin
            proc_step <= 2'd0;
            ir        <= '0;
            reg_a     <= '0;
            reg_g     <= '0;
            for (int i = 0; i < 4; i++) proc_r[i] <= '0;
        end else begin
            case (proc_step)
                2'd0: if (w) begin
                    ir        <= {F, Rx, Ry};
                    proc_step <= 2'd1;
                end
                2'd1: begin
                    if (ir[5:4] == OP_MVI) begin
                        proc_r[ir[3:2]] <= Data;
                        proc_step       <= 2'd0;
                    end else if (ir[5:4] == OP_MV) begin
                        proc_r[ir[3:2]] <= proc_r[ir[1:0]];
                        proc_step       <= 2'd0;
                    end else begin
                        reg_a     <= proc_r[ir[3:2]];
                        proc_step <= 2'd2;
                    end
                end
                2'd2: begin
                    reg_g     <= (ir[5:4] == OP_ADD) ? reg_a + proc_r[ir[1:0]]
                                                     : reg_a - proc_r[ir[1:0]];
                    proc_step <= 2'd3;
                end
                default: begin
                    proc_r[ir[3:2]] <= reg_g;
                    proc_step       <= 2'd0;
                end
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] exp_regs [4];
    int         cycle = 0;
    int         rv_count = 0;
    int         w_count = 0;
    int         last_w_cycle = 0;
    int         err_delta = -1;
    logic       prev_w = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_error = 1'b0;
    logic [13:0] prev_fields = '0;

    always @(negedge Clock) begin
        cycle++;
        if (result_valid) begin
            rv_count++;
            check("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("result_order", result, exp_q.pop_front());
        end
        if (w) begin
            w_count++;
            last_w_cycle = cycle;
            check("w_single_cycle", prev_w, 0);
            check("w_at_T0", proc_step, 0);
        end
        if (busy && prev_busy) check("fields_held", {F, Rx, Ry, Data}, prev_fields);
        if (error && !prev_error) err_delta = cycle - last_w_cycle;
        prev_w      = w;
        prev_busy   = busy;
        prev_error  = error;
        prev_fields = {F, Rx, Ry, Data};
    end

    // Called right after a negedge; returns at the next negedge.
    task automatic push(input logic [1:0] f, input logic [1:0] rx, input logic [1:0] ry,
                        input logic [7:0] d, input bit expect_result, output bit accepted);
        logic [7:0] v;
        in_valid = 1'b1;
        in_instr = {f, rx, ry};
        in_data  = d;
        accepted = in_ready;
        @(negedge Clock);
        in_valid = 1'b0;
        if (accepted) begin
            case (f)
                OP_MVI:  v = d;
                OP_MV:   v = exp_regs[ry];
                OP_ADD:  v = exp_regs[rx] + exp_regs[ry];
                default: v = exp_regs[rx] - exp_regs[ry];
            endcase
            exp_regs[rx] = v;
            if (expect_result) exp_q.push_back(v);
        end
    endtask

    task automatic wait_results(input int target, input int budget, input string tag);
        int n = 0;
        while (rv_count < target && n < budget) begin
            @(negedge Clock);
            n++;
        end
        #1;
        check(tag, rv_count, target);
    endtask

    initial begin
        bit acc;
        int n;
        int rv_base, w_base;
        for (int i = 0; i < 4; i++) exp_regs[i] = '0;
        Reset = 1'b1; run = 1'b0; in_valid = 1'b0; in_instr = '0; in_data = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Reset state
        check("reset_outputs", {w, F, Rx, Ry, Data, result, result_valid, busy, error, issued_cnt}, 0);
        check("reset_in_ready", in_ready, 1);

        // Single mvi R2 #0x5A
        run = 1'b1;
        push(OP_MVI, R2, R0, 8'h5A, 1'b1, acc);
        check("mvi_accepted", acc, 1);
        wait_results(1, 40, "mvi_result_count");
        check("mvi_result", result, 8'h5A);
        check("mvi_issued_cnt", issued_cnt, 1);
        check("mvi_w_pulses", w_count, 1);
        check("mvi_proc_R2", proc_r[2], 8'h5A);

        // mvi R0 #7, mvi R1 #3, sub R0,R1
        push(OP_MVI, R0, R0, 8'd7, 1'b1, acc);
        push(OP_MVI, R1, R0, 8'd3, 1'b1, acc);
        push(OP_SUB, R0, R1, 8'd0, 1'b1, acc);
        wait_results(4, 80, "sub_result_count");
        check("sub_result", result, 8'h04);
        check("sub_proc_R0", proc_r[0], 8'h04);
        check("sub_w_pulses", w_count, 4);
        check("sub_issued_cnt", issued_cnt, 4);

        // Fill to DEPTH with run low, then push while full in the first pop cycle
        run = 1'b0;
        for (int i = 0; i < 8; i++) push(OP_MVI, 2'(i % 4), R0, 8'(8'h10 + i), 1'b1, acc);
        check("full_in_ready_low", in_ready, 0);
        run = 1'b1;
        push(OP_MVI, R3, R0, 8'hFF, 1'b1, acc);
        check("full_push_dropped", acc, 0);
        wait_results(12, 200, "full_drain_count");
        check("full_last_result", result, 8'h17);
        check("full_issued_cnt", issued_cnt, 12);
        check("full_drained_in_ready", in_ready, 1);

        // Watchdog: Done withheld for the first instruction only
        hang = 1'b1;
        push(OP_MVI, R3, R0, 8'hEE, 1'b0, acc);
        push(OP_MVI, R1, R0, 8'h42, 1'b1, acc);
        n = 0;
        while (!error && n < 60) begin
            @(negedge Clock);
            n++;
        end
        #1;
        hang = 1'b0;
        check("wd_error_set", error, 1);
        check("wd_wait_cycles", err_delta, 16);
        check("wd_result_unchanged", result, 8'h17);
        check("wd_busy_low", busy, 0);
        wait_results(13, 60, "wd_next_issue_count");
        check("wd_next_result", result, 8'h42);
        check("wd_error_sticky", error, 1);
        check("wd_issued_cnt", issued_cnt, 13);

        // Reset during WAIT of an add with 3 entries queued
        @(negedge Clock);
        run = 1'b0;
        push(OP_ADD, R0, R1, 8'd0, 1'b1, acc);
        push(OP_MVI, R1, R0, 8'd1, 1'b1, acc);
        push(OP_MVI, R2, R0, 8'd2, 1'b1, acc);
        push(OP_MVI, R3, R0, 8'd3, 1'b1, acc);
        run = 1'b1;
        n = 0;
        while (!w && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("rst_add_issued", w, 1);
        repeat (2) @(negedge Clock);
        check("rst_in_wait", {busy, w}, 2'b10);
        rv_base = rv_count;
        w_base  = w_count;
        Reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_regs[i] = '0;
        @(negedge Clock);
        check("rst_mid_outputs", {w, F, Rx, Ry, Data, result, result_valid, busy, error, issued_cnt}, 0);
        check("rst_mid_in_ready", in_ready, 1);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        check("rst_no_result", rv_count, rv_base);
        check("rst_fifo_empty_no_issue", w_count, w_base);

        // Push and pop in the same cycle at occupancy 1
        run = 1'b0;
        push(OP_MVI, R0, R0, 8'h31, 1'b1, acc);
        run = 1'b1;
        push(OP_MVI, R1, R0, 8'h32, 1'b1, acc);
        check("occ1_push_accepted", acc, 1);
        wait_results(rv_base + 2, 40, "occ1_result_count");
        repeat (10) @(negedge Clock);
        check("occ1_no_duplicate", rv_count, rv_base + 2);
        check("occ1_last_result", result, 8'h32);
        check("occ1_issued_cnt", issued_cnt, 2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
